exe_stage: RTL

Execute stage of the 5-stage pipeline, between the ID/EX pipeline register and the EX/MEM pipeline register. Each cycle it:
- selects forwarded operands;
- evaluates the ALU command;
- resolves branches and computes the branch target.

`MUL` is executed by a 32-cycle iterative shift-add unit. While it runs, `busy` holds the front of the pipeline; `busy` drives the ID/EX register's `superStall`.

---
 rtl/exe_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and a 32-cycle
// iterative shift-add multiplier that stalls the front of the pipeline.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  EXE_Cmd,
    input  logic [1:0]  BR_Type,
    input  logic        Is_Imm,
    input  logic [31:0] Immediate,
    input  logic [31:0] PC,
    input  logic [31:0] readdata1,
    input  logic [31:0] readdata2,
    input  logic [1:0]  fwd_sel1,
    input  logic [1:0]  fwd_sel2,
    input  logic [31:0] mem_fwd_val,
    input  logic [31:0] wb_fwd_val,
    output logic [31:0] alu_result,
    output logic [31:0] st_val,
    output logic        branch_taken,
    output logic [31:0] br_addr,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_NOP = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SL0 = 4'b1000;
    localparam logic [3:0] CMD_SL1 = 4'b1001;
    localparam logic [3:0] CMD_SRA = 4'b1010;
    localparam logic [3:0] CMD_SRL = 4'b1011;
    localparam logic [3:0] CMD_MUL = 4'b1100;

    mul_state_e  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        is_mul;

    // Selectors 00 and 11 both pick the register-file value.
    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_val,
                                            input logic [31:0] mem_val, input logic [31:0] wb_val);
        case (sel)
            2'b01:   fwd_mux = mem_val;
            2'b10:   fwd_mux = wb_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

    assign op_a   = fwd_mux(fwd_sel1, readdata1, mem_fwd_val, wb_fwd_val);
    assign st_val = fwd_mux(fwd_sel2, readdata2, mem_fwd_val, wb_fwd_val);
    assign op_b   = Is_Imm ? Immediate : st_val;
    assign shamt  = op_b[4:0];
    assign is_mul = (EXE_Cmd == CMD_MUL);

    // Word offset: shifting left by two drops Immediate[31:30].
    assign br_addr     = PC + (Immediate << 2);
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = 32'd0;
                    count_d  = 5'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (rst) begin
            busy = (state_q == RUN) || ((state_q == IDLE) && is_mul);
        end

        branch_taken = 1'b0;
        case (BR_Type)
            2'b01:   branch_taken = (op_a == 32'd0);
            2'b10:   branch_taken = (op_a != st_val);
            2'b11:   branch_taken = 1'b1;
            default: branch_taken = 1'b0;
        endcase
        if (busy) begin
            branch_taken = 1'b0;
        end

        alu_result = 32'd0;
        case (EXE_Cmd)
            CMD_ADD: alu_result = op_a + op_b;
            CMD_NOP: alu_result = 32'd0;
            CMD_SUB: alu_result = op_a - op_b;
            CMD_AND: alu_result = op_a & op_b;
            CMD_OR:  alu_result = op_a | op_b;
            CMD_NOR: alu_result = ~(op_a | op_b);
            CMD_XOR: alu_result = op_a ^ op_b;
            CMD_SL0: alu_result = op_a << shamt;
            CMD_SL1: alu_result = op_a << shamt;
            CMD_SRA: alu_result = $unsigned($signed(op_a) >>> shamt);
            CMD_SRL: alu_result = op_a >> shamt;
            CMD_MUL: alu_result = (state_q == DONE) ? acc_q : 32'd0;
            default: alu_result = 32'd0;
        endcase
    end

endmodule
